bist_session_ctrl: RTL and testbench

Sequences one built-in self-test session for the s9234 core once the instruction decoder asserts BIST mode. It seeds and steps the pattern LFSR for a programmed number of cycles and compacts the core's primary outputs into a MISR. It then compares the MISR against a golden signature. Pass, done and the signature are exposed as a JTAG data register captured and shifted by the TAP controller.

---
 rtl/bist_session_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_bist_session_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_session_ctrl.sv
// bist_session_ctrl
//   Runs one built-in self-test session for the s9234 core. While BIST mode is
//   active and the TAP idles in Run-Test/Idle, the controller seeds the pattern
//   LFSR, steps it PAT_CNT times, and compacts the core responses into a MISR.
//   It keeps compacting for LAT more cycles so the core's response latency is
//   covered, then compares the MISR with GOLDEN_SIG. The result is readable
//   through a JTAG data register laid out as {misr, pass, done}.
//
// Ports
//   CK          TCK-domain clock
//   TRST        asynchronous active-low reset
//   bist_en     BIST instruction active (instruction decoder)
//   run_idle    TAP in Run-Test/Idle; when low, the session pauses
//   resp        core primary outputs, compacted into the MISR
//   capture_dr  load the data register from {misr, pass, done}
//   shift_dr    shift the data register right; tdi enters the MSB
//   tdi / tdo   serial in / serial out (tdo = data register bit 0)
//   lfsr_load   one-cycle seed strobe to the pattern LFSR
//   lfsr_en     pattern LFSR step enable
//   busy        session in progress (SEED through COMPARE)
//   done        session complete
//   pass        signature matched (meaningful while done = 1)
module bist_session_ctrl #(
    parameter int unsigned          PAT_CNT    = 131071,
    parameter int unsigned          RESP_W     = 39,
    parameter int unsigned          LAT        = 1,
    parameter logic [RESP_W-1:0]    POLY       = 39'h0000000011,
    parameter logic [RESP_W-1:0]    GOLDEN_SIG = 39'h0
) (
    input  logic              CK,
    input  logic              TRST,
    input  logic              bist_en,
    input  logic              run_idle,
    input  logic [RESP_W-1:0] resp,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              tdi,
    output logic              tdo,
    output logic              lfsr_load,
    output logic              lfsr_en,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int unsigned CNT_W = $clog2(PAT_CNT + 1);
    localparam int unsigned LAT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int unsigned SR_W  = RESP_W + 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEED    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [RESP_W-1:0] misr_q, misr_d;
    logic              pass_q, pass_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [RESP_W-1:0] misr_next;

    // One MISR step: shift left, fold the outgoing MSB back through POLY,
    // then XOR in the current response word.
    always_comb begin
        misr_next = {misr_q[RESP_W-2:0], 1'b0}
                  ^ (misr_q[RESP_W-1] ? POLY : '0)
                  ^ resp;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        misr_d  = misr_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                pass_d = 1'b0;
                if (bist_en && run_idle) begin
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                if (!bist_en) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    misr_d  = '0;
                    cnt_d   = '0;
                    lat_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bist_en) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else if (run_idle) begin
                    misr_d = misr_next;
                    // Terminal step leaves the counter at PAT_CNT, which the
                    // counter width still holds, so it never wraps.
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PAT_CNT - 1)) begin
                        state_d = (LAT == 0) ? S_COMPARE : S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!bist_en) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else if (run_idle) begin
                    misr_d = misr_next;
                    lat_d  = lat_q + LAT_W'(1);
                    if (lat_q == LAT_W'(LAT - 1)) begin
                        state_d = S_COMPARE;
                    end
                end
            end
            S_COMPARE: begin
                if (!bist_en) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    pass_d  = (misr_q == GOLDEN_SIG);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bist_en) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pass_d  = 1'b0;
            end
        endcase
    end

    // JTAG data register; capture wins over shift.
    always_comb begin
        sr_d = sr_q;
        if (capture_dr) begin
            sr_d = {misr_q, pass_q, (state_q == S_DONE)};
        end else if (shift_dr) begin
            sr_d = {tdi, sr_q[SR_W-1:1]};
        end
    end

    always_ff @(posedge CK or negedge TRST) begin
        if (!TRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            misr_q  <= '0;
            pass_q  <= 1'b0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            misr_q  <= misr_d;
            pass_q  <= pass_d;
            sr_q    <= sr_d;
        end
    end

    always_comb begin
        lfsr_load = (state_q == S_SEED);
        lfsr_en   = (state_q == S_RUN) && run_idle;
        busy      = (state_q == S_SEED) || (state_q == S_RUN) ||
                    (state_q == S_FLUSH) || (state_q == S_COMPARE);
        done      = (state_q == S_DONE);
        pass      = pass_q;
        tdo       = sr_q[0];
    end

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Bench for bist_session_ctrl. Two small instances (PAT_CNT=8, RESP_W=4,
// POLY=4'h3, LAT=1, golden 8 and 9) share one set of inputs; a wide instance
// (PAT_CNT=200, RESP_W=39, LAT=0, golden 0) has its own. Expected MISR values
// come from a session-level model: every run_idle cycle after seeding is one
// compaction until PAT_CNT+LAT have happened, then one compare cycle.
module tb_bist_session_ctrl;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic        TRST;
    logic        cap, shf, tdi;
    logic        bist_s, idle_s;
    logic [3:0]  resp_s;
    logic        bist_l, idle_l;
    logic [38:0] resp_l;

    logic tdo_a, load_a, en_a, busy_a, done_a, pass_a;
    logic tdo_b, load_b, en_b, busy_b, done_b, pass_b;
    logic tdo_c, load_c, en_c, busy_c, done_c, pass_c;

    int n_chk  = 0;
    int n_fail = 0;

    bist_session_ctrl #(.PAT_CNT(8), .RESP_W(4), .LAT(1), .POLY(4'h3), .GOLDEN_SIG(4'h8)) ua (
        .CK(CK), .TRST(TRST), .bist_en(bist_s), .run_idle(idle_s), .resp(resp_s),
        .capture_dr(cap), .shift_dr(shf), .tdi(tdi), .tdo(tdo_a), .lfsr_load(load_a),
        .lfsr_en(en_a), .busy(busy_a), .done(done_a), .pass(pass_a));

    bist_session_ctrl #(.PAT_CNT(8), .RESP_W(4), .LAT(1), .POLY(4'h3), .GOLDEN_SIG(4'h9)) ub (
        .CK(CK), .TRST(TRST), .bist_en(bist_s), .run_idle(idle_s), .resp(resp_s),
        .capture_dr(cap), .shift_dr(shf), .tdi(tdi), .tdo(tdo_b), .lfsr_load(load_b),
        .lfsr_en(en_b), .busy(busy_b), .done(done_b), .pass(pass_b));

    bist_session_ctrl #(.PAT_CNT(200), .RESP_W(39), .LAT(0), .POLY(39'h11), .GOLDEN_SIG(39'h0)) uc (
        .CK(CK), .TRST(TRST), .bist_en(bist_l), .run_idle(idle_l), .resp(resp_l),
        .capture_dr(cap), .shift_dr(shf), .tdi(tdi), .tdo(tdo_c), .lfsr_load(load_c),
        .lfsr_en(en_c), .busy(busy_c), .done(done_c), .pass(pass_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // group 0 = small pair (ua/ub), group 1 = wide instance (uc)
    function automatic int pat_of(input int g);  return (g == 0) ? 8 : 200; endfunction
    function automatic int lat_of(input int g);  return (g == 0) ? 1 : 0;   endfunction
    function automatic int w_of(input int g);    return (g == 0) ? 4 : 39;  endfunction
    function automatic logic [63:0] poly_of(input int g);
        return (g == 0) ? 64'h3 : 64'h11;
    endfunction

    // {lfsr_load, lfsr_en, busy, done, pass, tdo}; 0 = ua, 1 = uc, 2 = ub
    function automatic logic [5:0] outs(input int g);
        if (g == 0)      return {load_a, en_a, busy_a, done_a, pass_a, tdo_a};
        else if (g == 1) return {load_c, en_c, busy_c, done_c, pass_c, tdo_c};
        else             return {load_b, en_b, busy_b, done_b, pass_b, tdo_b};
    endfunction

    function automatic logic [63:0] misr_step(input logic [63:0] m, input logic [63:0] r,
                                              input int w, input logic [63:0] poly);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return ((m << 1) ^ (m[w-1] ? poly : 64'd0) ^ r) & mask;
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic drive(input int g, input logic b, input logic i, input logic [63:0] r);
        if (g == 0) begin
            bist_s = b; idle_s = i; resp_s = r[3:0];
        end else begin
            bist_l = b; idle_l = i; resp_l = r[38:0];
        end
    endtask

    // Capture then shift out 41 bits; v[0] = done, v[1] = pass, v[2+] = misr.
    task automatic read_dr(output logic [63:0] va, output logic [63:0] vb, output logic [63:0] vc);
        va = '0; vb = '0; vc = '0;
        cap = 1'b1;
        tick();
        cap = 1'b0;
        shf = 1'b1;
        for (int i = 0; i < 41; i++) begin
            va[i] = tdo_a; vb[i] = tdo_b; vc[i] = tdo_c;
            tdi = 1'($urandom);
            tick();
        end
        shf = 1'b0;
    endtask

    // Runs a session from IDLE. Returns early (state RUN) once abort_at
    // compactions have happened, when abort_at >= 0.
    task automatic session(input int g, input int pause_at, input int pause_len, input bit rnd,
                           input logic [63:0] fixed_resp, input int abort_at,
                           output logic [63:0] m);
        int p, l, w, k, edges, pauses, en_obs, cyc;
        logic i_;
        logic [63:0] r, mask;
        logic [5:0] o;
        p = pat_of(g); l = lat_of(g); w = w_of(g);
        mask = (64'd1 << w) - 64'd1;
        m = '0; k = 0; pauses = 0; en_obs = 0; cyc = 0;
        drive(g, 1'b1, 1'b1, fixed_resp);
        tick(); edges = 1;
        o = outs(g);
        chk("seed_load", o[5], 1'b1);
        chk("seed_busy", o[3], 1'b1);
        tick(); edges++;
        o = outs(g);
        chk("run_load_off", o[5], 1'b0);
        while (k < p + l) begin
            if (abort_at >= 0 && k == abort_at) return;
            if (cyc > 4 * (p + l) + 50) begin
                chk("timeout_k", 64'(k), 64'(p + l));
                return;
            end
            i_ = 1'b1;
            if (pause_at >= 0 && cyc >= pause_at && cyc < pause_at + pause_len) i_ = 1'b0;
            if (rnd && $urandom_range(0, 3) == 0) i_ = 1'b0;
            r = rnd ? ({$urandom, $urandom} & mask) : fixed_resp;
            drive(g, 1'b1, i_, r);
            #1;
            o = outs(g);
            chk("lfsr_en", o[4], i_ && (k < p));
            chk("lfsr_load_off", o[5], 1'b0);
            chk("done_early", o[2], 1'b0);
            if (o[4]) en_obs++;
            tick(); edges++; cyc++;
            if (i_) begin
                m = misr_step(m, r, w, poly_of(g));
                k++;
            end else begin
                pauses++;
            end
        end
        drive(g, 1'b1, 1'b1, 64'd0);
        tick(); edges++;
        o = outs(g);
        chk("done", o[2], 1'b1);
        chk("busy_off", o[3], 1'b0);
        chk("edges_to_done", 64'(edges), 64'(p + l + 3 + pauses));
        chk("en_cycles", 64'(en_obs), 64'(p));
        if (g == 0) begin
            chk("pass_a", pass_a, m == 64'h8);
            chk("pass_b", pass_b, m == 64'h9);
        end else begin
            chk("pass_c", pass_c, m == 64'h0);
        end
        tick();
        o = outs(g);
        chk("done_hold", o[2], 1'b1);
        chk("no_rerun", o[5], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] m, va, vb, vc;
        logic [5:0]  o;
        TRST = 1'b0;
        cap = 1'b0; shf = 1'b0; tdi = 1'b0;
        drive(0, 1'b0, 1'b0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0);
        #12;
        o = outs(0); chk("rst_outs_a", o, 6'b0);
        o = outs(1); chk("rst_outs_c", o, 6'b0);
        TRST = 1'b1;
        tick();

        // Directed: resp held at 1, no pauses.
        session(0, -1, 0, 1'b0, 64'h1, -1, m);
        read_dr(va, vb, vc);
        chk("misr_dir", va[5:2], 4'h8);
        chk("tdo_seq", va[5:0], 6'b100011);
        chk("dr_pass_b", vb[1:0], 2'b01);
        drive(0, 1'b0, 1'b0, 64'd0);
        tick();
        o = outs(0); chk("pass_clear", o[1], 1'b0);
        chk("done_clear", o[2], 1'b0);

        // Directed: three-cycle pause in the middle of RUN.
        session(0, 3, 3, 1'b0, 64'h1, -1, m);
        read_dr(va, vb, vc);
        chk("misr_pause", va[5:2], 4'h8);
        drive(0, 1'b0, 1'b0, 64'd0);
        tick();

        // Random responses and pauses on the small pair.
        for (int s = 0; s < 3; s++) begin
            session(0, -1, 0, 1'b1, 64'd0, -1, m);
            read_dr(va, vb, vc);
            chk("misr_rnd_a", va[5:2], m[3:0]);
            chk("misr_rnd_b", vb[5:2], m[3:0]);
            drive(0, 1'b0, 1'b0, 64'd0);
            tick();
        end

        // Abort after four compactions; misr must be retained.
        session(0, -1, 0, 1'b0, 64'h1, 4, m);
        drive(0, 1'b0, 1'b1, 64'd0);
        tick();
        o = outs(0);
        chk("abort_outs", o[5:1], 5'b0);
        read_dr(va, vb, vc);
        chk("abort_misr", va[5:2], m[3:0]);
        chk("abort_pass_done", va[1:0], 2'b00);
        drive(0, 1'b1, 1'b1, 64'd0);
        tick();
        o = outs(0); chk("restart_load", o[5], 1'b1);
        tick();
        o = outs(0); chk("restart_load_off", o[5], 1'b0);
        drive(0, 1'b0, 1'b0, 64'd0);
        tick();

        // Asynchronous reset in the middle of RUN.
        drive(0, 1'b1, 1'b1, 64'h5);
        repeat (4) tick();
        #2 TRST = 1'b0;
        #1;
        o = outs(0); chk("arst_outs_a", o, 6'b0);
        o = outs(2); chk("arst_outs_b", o, 6'b0);
        drive(0, 1'b0, 1'b0, 64'd0);
        #1 TRST = 1'b1;
        tick();
        read_dr(va, vb, vc);
        chk("arst_dr", va[5:0], 6'b0);

        // Wide instance, LAT = 0: random session, then an all-zero session.
        session(1, -1, 0, 1'b1, 64'd0, -1, m);
        read_dr(va, vb, vc);
        chk("misr_wide", vc[40:2], m[38:0]);
        chk("dr_pass_wide", vc[1], m == 64'h0);
        drive(1, 1'b0, 1'b0, 64'd0);
        tick();
        o = outs(1); chk("pass_clear_c", o[1], 1'b0);
        session(1, -1, 0, 1'b0, 64'd0, -1, m);
        read_dr(va, vb, vc);
        chk("dr_zero_wide", vc[40:0], 41'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
